pipeline_lsu: RTL and testbench
===============================

Name: pipeline_lsu

Overview:
Load/store unit forming the MEM stage of pipeline_cpu, between the EX/MEM pipeline register and data RAM.
- Accepts one memory op per cycle from EX and drives a valid/ready data-memory port.
- Performs byte-lane steering for stores and extraction/extension for loads.
- Stalls upstream while memory is busy.
- Registers the MEM/WB result and flags misaligned accesses and bus timeouts.

Parameters:
ADDR_W, 32, byte-address width
TIMEOUT, 16, max cycles waiting for dmem_ready before bus error (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ex_valid  in  1  EX/MEM slot holds a real instruction
ex_mem_op  in  4  mem_op_t operation
ex_addr  in  ADDR_W  effective byte address
ex_wdata  in  32  store data (rt)
ex_alu_result  in  32  result for non-memory ops
ex_rd  in  5  destination register
ex_reg_write  in  1  instruction writes rd
stall_out  out  1  hold IF/ID/EX and EX/MEM register
dmem_req  out  1  memory request valid
dmem_we  out  1  write request
dmem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables, bit i = byte lane i
dmem_ready  in  1  transfer completes on rising edge where req&ready
dmem_rdata  in  32  read word, valid when dmem_ready=1
wb_valid  out  1  MEM/WB slot valid
wb_rd  out  5
wb_reg_write  out  1
wb_data  out  32
misalign_exc  out  1  one-cycle pulse
bus_err  out  1  one-cycle pulse
fault_addr  out  ADDR_W  address of last misaligned/timed-out access, held

Behaviour:
- Reset (reset=0, async):
  - State IDLE, timeout counter 0.
  - All registered outputs 0, fault_addr 0.
  - dmem_req and stall_out are forced 0 while reset is low, including when reset is asserted in WAIT. The pending access is abandoned and memory must tolerate this.
- Little-endian lanes: byte k = data[8k+7:8k].
- States: IDLE, WAIT.
- IDLE:
  - Memory op, valid and aligned: drive dmem_* combinationally from ex_* inputs.
    - If dmem_ready=1: complete, stall_out=0, and register WB at the edge (single-cycle MEM).
    - Otherwise: stall_out=1, latch the request (addr, op, wdata, rd, reg_write), counter=1, go to WAIT.
  - Non-memory op: wb_data<=ex_alu_result, wb_rd/wb_reg_write pass through, wb_valid<=1.
  - ex_valid=0: wb_valid<=0, wb_reg_write<=0.
- WAIT:
  - dmem_* are driven from latched registers and are stable until completion.
  - stall_out = !dmem_ready, and wb_valid<=0 each stalled cycle (bubble).
  - dmem_ready=1: register WB from the latched request, go to IDLE, stall_out=0 in that cycle.
  - Counter reaches TIMEOUT without ready: drop the request, bus_err pulse, fault_addr<=addr, wb_valid<=1 with wb_reg_write<=0, go to IDLE, stall_out=0.
- Alignment:
  - LH/LHU/SH fault on addr[0]=1.
  - LW/SW fault on addr[1:0]!=0.
  - On a fault: no dmem_req, misalign_exc pulses at the next edge, fault_addr<=addr, wb_valid<=1 with wb_reg_write<=0, no stall.
- Stores:
  - SB: be=1<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - SW: be=1111.
  - Stores set wb_reg_write=0.
- Loads: dmem_be=1111, dmem_we=0.
  - LB/LBU select byte addr[1:0], sign-/zero-extend.
  - LH/LHU select half addr[1], sign-/zero-extend.
  - LW takes the whole word.
- Simultaneous: misalignment takes precedence over request issue. reset takes precedence over everything.

Decomposition:
- cpu_pkg holds:
  - mem_op_t: MEM_NONE=0, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW.
  - lsu_state_t {IDLE, WAIT}.
  - Helper functions is_load/is_store.
- Sub-module lsu_align (combinational): takes op/addr/wdata/rdata, returns be, steered wdata, extended load data and the misaligned flag.

Test Plan:
1. dmem_ready tied 1. SW rt=0x1234 addr 0x40 -> dmem_req=1, we=1, be=1111, addr 0x40, wdata 0x1234, stall_out=0. Then LW 0x40 rd=9 with rdata 0x1234 -> next edge wb_data=0x1234, wb_rd=9, wb_reg_write=1.
2. LW with dmem_ready delayed 3 cycles -> stall_out=1 for exactly 3 cycles, dmem_addr stable, wb_valid=0 while stalled, then wb_data=rdata with a single WB write.
3. rdata 0x80FF1234:
   - LB 0x43 -> 0xFFFFFF80
   - LBU 0x43 -> 0x00000080
   - LH 0x42 -> 0xFFFF80FF
   - LHU 0x42 -> 0x000080FF
4. Stores:
   - SB 0xAB at 0x41 -> be=0010, wdata 0xABABABAB
   - SH 0xBEEF at 0x42 -> be=1100, wdata 0xBEEFBEEF
   - SH at 0x41 -> misalign_exc pulse, fault_addr 0x41, no dmem_req
5. dmem_ready held 0 -> bus_err pulses after TIMEOUT=16 cycles, fault_addr=addr, dmem_req drops, wb_reg_write=0, pipeline resumes.
6. reset driven low mid-WAIT -> dmem_req and stall_out 0 immediately, wb_valid=0. After release, ALU op rd=2 result 0xA -> wb_data=0x0000000A, wb_rd=2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared MEM-stage types: memory operation encoding, LSU state and op classifiers.
package cpu_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB,
    MEM_LBU,
    MEM_LH,
    MEM_LHU,
    MEM_LW,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_t;

  typedef enum logic {IDLE, WAIT} lsu_state_t;

  function automatic logic is_load(input mem_op_t op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, alignment check.
module lsu_align
  import cpu_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = 8'(rdata >> {addr_lo, 3'b000});
  assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'b0000;
    st_data    = wdata;
    ld_data    = rdata;
    misaligned = 1'b0;
    case (op)
      MEM_LB:  begin be = 4'b1111; ld_data = {{24{lane_b[7]}}, lane_b}; end
      MEM_LBU: begin be = 4'b1111; ld_data = {24'd0, lane_b}; end
      MEM_LH:  begin be = 4'b1111; ld_data = {{16{lane_h[15]}}, lane_h}; misaligned = addr_lo[0]; end
      MEM_LHU: begin be = 4'b1111; ld_data = {16'd0, lane_h}; misaligned = addr_lo[0]; end
      MEM_LW:  begin be = 4'b1111; misaligned = |addr_lo; end
      MEM_SB:  begin be = 4'b0001 << addr_lo; st_data = {4{wdata[7:0]}}; end
      MEM_SH:  begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_data    = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      MEM_SW:  begin be = 4'b1111; misaligned = |addr_lo; end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_lsu.sv
// MEM stage: issues data-memory accesses, stalls upstream while waiting, registers MEM/WB.
// state | meaning
// IDLE  | accepting ops from EX; dmem port driven straight from ex_* inputs
// WAIT  | access outstanding; dmem port driven from latched request, counting to TIMEOUT
module pipeline_lsu
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [3:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [31:0]       ex_alu_result,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [31:0]       wb_data,
  output logic              misalign_exc,
  output logic              bus_err,
  output logic [ADDR_W-1:0] fault_addr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t        state;
  logic [CNT_W-1:0]  cnt;
  mem_op_t           lat_op;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [4:0]        lat_rd;
  logic              lat_reg_write;

  mem_op_t           ex_op, cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata, al_wdata, al_ldata;
  logic [3:0]        al_be;
  logic              al_misaligned, ex_mem, in_wait, timed_out;

  assign ex_op     = mem_op_t'(ex_mem_op);
  assign ex_mem    = ex_valid && (is_load(ex_op) || is_store(ex_op));
  assign in_wait   = (state == WAIT);
  assign timed_out = in_wait && (cnt == CNT_W'(TIMEOUT));

  // One aligner serves both the fresh EX op and the latched outstanding one.
  assign cur_op    = in_wait ? lat_op    : ex_op;
  assign cur_addr  = in_wait ? lat_addr  : ex_addr;
  assign cur_wdata = in_wait ? lat_wdata : ex_wdata;

  lsu_align u_align (
    .op         (cur_op),
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .st_data    (al_wdata),
    .ld_data    (al_ldata),
    .misaligned (al_misaligned)
  );

  assign dmem_req   = reset && (in_wait ? !timed_out : (ex_mem && !al_misaligned));
  assign stall_out  = dmem_req && !dmem_ready;
  assign dmem_we    = is_store(cur_op);
  assign dmem_addr  = {cur_addr[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = al_wdata;
  assign dmem_be    = al_be;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_op        <= MEM_NONE;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_rd        <= '0;
      lat_reg_write <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_data       <= '0;
      misalign_exc  <= 1'b0;
      bus_err       <= 1'b0;
      fault_addr    <= '0;
    end else begin
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (!ex_valid) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end else if (!ex_mem) begin
            wb_valid     <= 1'b1;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write;
            wb_data      <= ex_alu_result;
          end else if (al_misaligned) begin
            wb_valid     <= 1'b1;
            wb_rd        <= ex_rd;
            wb_reg_write <= 1'b0;
            misalign_exc <= 1'b1;
            fault_addr   <= ex_addr;
          end else if (dmem_ready) begin
            wb_valid     <= 1'b1;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write && is_load(ex_op);
            wb_data      <= al_ldata;
          end else begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            lat_op        <= ex_op;
            lat_addr      <= ex_addr;
            lat_wdata     <= ex_wdata;
            lat_rd        <= ex_rd;
            lat_reg_write <= ex_reg_write;
            cnt           <= CNT_W'(1);
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (timed_out) begin
            wb_valid     <= 1'b1;
            wb_rd        <= lat_rd;
            wb_reg_write <= 1'b0;
            bus_err      <= 1'b1;
            fault_addr   <= lat_addr;
            cnt          <= '0;
            state        <= IDLE;
          end else if (dmem_ready) begin
            wb_valid     <= 1'b1;
            wb_rd        <= lat_rd;
            wb_reg_write <= lat_reg_write && is_load(lat_op);
            wb_data      <= al_ldata;
            cnt          <= '0;
            state        <= IDLE;
          end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            cnt          <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_lsu.sv
// Directed bench for pipeline_lsu: per-cycle reference model plus literal spot checks.
module tb_pipeline_lsu;

  localparam int TO = 16;
  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_mem_op = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0, ex_alu_result = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_reg_write, misalign_exc, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, fault_addr;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_mem_op(ex_mem_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_alu_result(ex_alu_result), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .misalign_exc(misalign_exc), .bus_err(bus_err), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Access size in bytes; 0 for anything that is not a memory op.
  function automatic int f_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit f_store(input logic [3:0] op);
    return op >= OP_SB && op <= OP_SW;
  endfunction

  function automatic bit f_misal(input logic [3:0] op, input logic [31:0] addr);
    return (addr % f_size(op)) != 0;
  endfunction

  function automatic logic [3:0] f_be(input logic [3:0] op, input logic [31:0] addr);
    if (!f_store(op)) return 4'hF;
    return 4'(((1 << f_size(op)) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] f_wdata(input logic [3:0] op, input logic [31:0] wd);
    case (f_size(op))
      1:       return 32'(wd[7:0]) * 32'h01010101;
      2:       return 32'(wd[15:0]) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    longint v;
    int bits;
    bits = 8 * f_size(op);
    v = longint'(rd >> (8 * (addr % 4))) & ((64'sd1 << bits) - 1);
    if ((op == OP_LB || op == OP_LH) && v >= (64'sd1 << (bits - 1)))
      v = v - (64'sd1 << bits);
    return 32'(v);
  endfunction

  // Reference model: what is outstanding and what the registered outputs must hold.
  bit          m_busy = 0;
  int          m_w = 0;
  logic [3:0]  m_op;
  logic [31:0] m_addr, m_wd;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic        e_wbv = 0, e_wbrw = 0, e_mis = 0, e_berr = 0;
  logic [4:0]  e_rd = 0;
  logic [31:0] e_data = 0, e_fault = 0;

  always @(negedge clk) begin
    logic [3:0]  op;
    logic [31:0] addr, wd;
    logic [4:0]  rd;
    logic        rw, ismem, mis, exp_req;
    if (!reset) begin
      m_busy = 0; m_w = 0;
      e_wbv = 0; e_wbrw = 0; e_mis = 0; e_berr = 0; e_rd = 0; e_data = 0; e_fault = 0;
    end
    op   = m_busy ? m_op   : (ex_valid ? ex_mem_op : OP_NONE);
    addr = m_busy ? m_addr : ex_addr;
    wd   = m_busy ? m_wd   : ex_wdata;
    rd   = m_busy ? m_rd   : ex_rd;
    rw   = m_busy ? m_rw   : ex_reg_write;
    ismem   = f_size(op) != 0;
    mis     = !m_busy && ismem && f_misal(op, addr);
    exp_req = reset && (m_busy ? (m_w < TO) : (ismem && !mis));

    chk("dmem_req", 32'(dmem_req), 32'(exp_req));
    chk("stall_out", 32'(stall_out), 32'(exp_req && !dmem_ready));
    if (exp_req) begin
      chk("dmem_we", 32'(dmem_we), 32'(f_store(op)));
      chk("dmem_addr", dmem_addr, addr & ~32'd3);
      chk("dmem_be", 32'(dmem_be), 32'(f_be(op, addr)));
      if (f_store(op)) chk("dmem_wdata", dmem_wdata, f_wdata(op, wd));
    end
    chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
    chk("wb_reg_write", 32'(wb_reg_write), 32'(e_wbrw));
    chk("misalign_exc", 32'(misalign_exc), 32'(e_mis));
    chk("bus_err", 32'(bus_err), 32'(e_berr));
    chk("fault_addr", fault_addr, e_fault);
    if (e_wbv) chk("wb_rd", 32'(wb_rd), 32'(e_rd));
    if (e_wbv && e_wbrw) chk("wb_data", wb_data, e_data);

    if (reset) begin
      e_mis = 0; e_berr = 0;
      if (m_busy && m_w == TO) begin
        e_wbv = 1; e_wbrw = 0; e_rd = m_rd; e_berr = 1; e_fault = m_addr; m_busy = 0; m_w = 0;
      end else if (exp_req && dmem_ready) begin
        e_wbv = 1; e_rd = rd; e_wbrw = rw && !f_store(op);
        if (!f_store(op)) e_data = f_load(op, addr, dmem_rdata);
        m_busy = 0; m_w = 0;
      end else if (exp_req) begin
        if (!m_busy) begin m_op = op; m_addr = addr; m_wd = wd; m_rd = rd; m_rw = rw; end
        m_busy = 1; m_w++; e_wbv = 0; e_wbrw = 0;
      end else if (mis) begin
        e_wbv = 1; e_wbrw = 0; e_rd = rd; e_mis = 1; e_fault = addr;
      end else if (ex_valid) begin
        e_wbv = 1; e_wbrw = ex_reg_write; e_rd = ex_rd; e_data = ex_alu_result;
      end else begin
        e_wbv = 0; e_wbrw = 0;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                        input logic [31:0] rdata);
    ex_valid = 1'b1; ex_mem_op = op; ex_addr = addr; ex_wdata = wd;
    ex_alu_result = alu; ex_rd = rd; ex_reg_write = rw; dmem_rdata = rdata;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_mem_op = OP_NONE; dmem_ready = 1'b0;
  endtask

  initial begin
    int stalls;
    #2;
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst fault_addr", fault_addr, 32'd0);
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    cycle(); cycle(); cycle();
    reset = 1'b1;
    cycle();

    // 1: single-cycle store then load
    set_op(OP_SW, 32'h40, 32'h1234, 0, 0, 0, 0); dmem_ready = 1'b1;
    #3;
    chk("sw req", 32'(dmem_req), 32'd1);
    chk("sw we", 32'(dmem_we), 32'd1);
    chk("sw be", 32'(dmem_be), 32'hF);
    chk("sw addr", dmem_addr, 32'h40);
    chk("sw wdata", dmem_wdata, 32'h1234);
    chk("sw stall", 32'(stall_out), 32'd0);
    cycle();
    set_op(OP_LW, 32'h40, 0, 0, 5'd9, 1, 32'h1234);
    cycle();
    chk("lw data", wb_data, 32'h1234);
    chk("lw rd", 32'(wb_rd), 32'd9);
    chk("lw rw", 32'(wb_reg_write), 32'd1);

    // 2: load with ready delayed 3 cycles
    set_op(OP_LW, 32'h44, 0, 0, 5'd5, 1, 32'hCAFEF00D);
    stalls = 0;
    for (int c = 0; c < 4; c++) begin
      dmem_ready = (c == 3);
      #3;
      if (stall_out) stalls++;
      chk("wait addr", dmem_addr, 32'h44);
      cycle();
    end
    chk("stall count", 32'(stalls), 32'd3);
    chk("delayed data", wb_data, 32'hCAFEF00D);
    chk("delayed valid", 32'(wb_valid), 32'd1);
    idle(); cycle();
    chk("single wb", 32'(wb_valid), 32'd0);

    // 3: load extraction and extension
    dmem_ready = 1'b1;
    set_op(OP_LB, 32'h43, 0, 0, 5'd1, 1, 32'h80FF1234); cycle();
    chk("lb", wb_data, 32'hFFFFFF80);
    set_op(OP_LBU, 32'h43, 0, 0, 5'd1, 1, 32'h80FF1234); cycle();
    chk("lbu", wb_data, 32'h00000080);
    set_op(OP_LH, 32'h42, 0, 0, 5'd1, 1, 32'h80FF1234); cycle();
    chk("lh", wb_data, 32'hFFFF80FF);
    set_op(OP_LHU, 32'h42, 0, 0, 5'd1, 1, 32'h80FF1234); cycle();
    chk("lhu", wb_data, 32'h000080FF);

    // 4: store steering and misaligned halfword
    set_op(OP_SB, 32'h41, 32'hAB, 0, 0, 0, 0); #3;
    chk("sb be", 32'(dmem_be), 32'b0010);
    chk("sb wdata", dmem_wdata, 32'hABABABAB);
    cycle();
    set_op(OP_SH, 32'h42, 32'hBEEF, 0, 0, 0, 0); #3;
    chk("sh be", 32'(dmem_be), 32'b1100);
    chk("sh wdata", dmem_wdata, 32'hBEEFBEEF);
    cycle();
    set_op(OP_SH, 32'h41, 32'hBEEF, 0, 0, 0, 0); #3;
    chk("mis req", 32'(dmem_req), 32'd0);
    cycle();
    chk("mis pulse", 32'(misalign_exc), 32'd1);
    chk("mis fault", fault_addr, 32'h41);
    idle(); cycle();
    chk("mis pulse end", 32'(misalign_exc), 32'd0);

    // Sweep every load/store at every byte offset
    for (int o = OP_LB; o <= OP_SW; o++) begin
      for (int a = 0; a < 4; a++) begin
        set_op(4'(o), 32'h100 + 32'(a), 32'h5A6B7C8D, 0, 5'(a + 10), 1, 32'hF1E2D3C4);
        dmem_ready = 1'b1;
        cycle();
      end
    end
    set_op(OP_NONE, 0, 0, 32'h77, 5'd3, 0, 0); cycle();
    set_op(OP_NONE, 0, 0, 32'h99, 5'd4, 1, 0); cycle();
    idle(); cycle();

    // 5: bus timeout
    set_op(OP_LW, 32'h50, 0, 0, 5'd7, 1, 32'h0);
    dmem_ready = 1'b0;
    stalls = 0;
    for (int c = 0; c <= TO; c++) begin
      #3;
      if (stall_out) stalls++;
      cycle();
    end
    chk("to stalls", 32'(stalls), 32'(TO));
    chk("to bus_err", 32'(bus_err), 32'd1);
    chk("to fault", fault_addr, 32'h50);
    chk("to rw", 32'(wb_reg_write), 32'd0);
    set_op(OP_NONE, 0, 0, 32'h55, 5'd6, 1, 0); cycle();
    chk("resume data", wb_data, 32'h55);
    chk("resume berr", 32'(bus_err), 32'd0);

    // 6: reset asserted while waiting
    set_op(OP_LW, 32'h60, 0, 0, 5'd4, 1, 0);
    dmem_ready = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    #1;
    chk("rstw req", 32'(dmem_req), 32'd0);
    chk("rstw stall", 32'(stall_out), 32'd0);
    chk("rstw wb_valid", 32'(wb_valid), 32'd0);
    idle();
    cycle();
    reset = 1'b1;
    set_op(OP_NONE, 0, 0, 32'hA, 5'd2, 1, 0); cycle();
    chk("post rst data", wb_data, 32'h0000000A);
    chk("post rst rd", 32'(wb_rd), 32'd2);
    idle(); cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
